// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared types and helpers for the four-source round-robin bus arbiter.
package rr_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Expand a 2-bit source index into a 4-bit one-hot vector.
    function automatic logic [3:0] onehot2(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter4_if.sv
// Request/grant and shared-bus signals of the four-source arbiter.
interface rr_bus_arbiter4_if #(
    parameter int DATA_W = 16
);
    logic [3:0]        req;
    logic [3:0]        last;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic [3:0]        grant;
    logic [1:0]        select;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;

    // Sources side: drives requests and data, observes grant and bus.
    modport master (
        output req, last, data0, data1, data2, data3,
        input  grant, select, bus_data, bus_valid
    );

    // Arbiter side.
    modport slave (
        input  req, last, data0, data1, data2, data3,
        output grant, select, bus_data, bus_valid
    );
endinterface

// File: rtl/Mux_4_to_1.sv
// Shared 4-to-1 word mux; the clk pin exists for drop-in compatibility only.
module Mux_4_to_1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);
    logic unused_clk_s;
    assign unused_clk_s = clk;

    // Pure combinational word selection.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end
endmodule

// File: rtl/rr_bus_arbiter4_pick4.sv
// Rotating priority picker: first set mask bit starting at ptr, wrapping mod 4.
module rr_pick4 (
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);
    // Scan ptr, ptr+1, ptr+2, ptr+3 and keep the first hit.
    always_comb begin
        logic       found_s;
        logic [1:0] cand_s;
        idx     = ptr;
        any     = |mask;
        found_s = 1'b0;
        cand_s  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr + 2'(k);
            if (!found_s && mask[cand_s]) begin
                idx     = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter and beat sequencer for a shared 4-source data bus.
module rr_bus_arbiter4 #(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_bus_arbiter4_if.slave bus
);
    import rr_arb_pkg::*;

    // Beat counter value on which the owner's final allowed beat happens.
    localparam logic [3:0] LIMIT = 4'(MAX_HOLD - 1);

    arb_state_e        state_r;
    logic [1:0]        ptr_r;
    logic [3:0]        beat_cnt_r;
    logic [3:0]        grant_r;
    logic [1:0]        select_r;
    logic [DATA_W-1:0] bus_data_r;
    logic              bus_valid_r;

    logic              owner_req_s;
    logic              owner_last_s;
    logic              beat_s;
    logic              release_s;
    logic [3:0]        pick_mask_s;
    logic [1:0]        pick_ptr_s;
    logic [1:0]        pick_idx_s;
    logic              pick_any_s;
    logic [DATA_W-1:0] mux_data_s;

    assign bus.grant     = grant_r;
    assign bus.select    = select_r;
    assign bus.bus_data  = bus_data_r;
    assign bus.bus_valid = bus_valid_r;

    // While busy select_r is the owner, so only its req/last bits matter.
    assign owner_req_s  = bus.req[select_r];
    assign owner_last_s = bus.last[select_r];

    // Beat/release decode and picker inputs; on release the owner is masked
    // out and priority starts just past it.
    always_comb begin
        beat_s      = 1'b0;
        release_s   = 1'b0;
        pick_mask_s = bus.req;
        pick_ptr_s  = ptr_r;
        if (state_r == BUSY) begin
            beat_s      = owner_req_s;
            release_s   = !owner_req_s || owner_last_s || (beat_cnt_r == LIMIT);
            pick_mask_s = bus.req & ~onehot2(select_r);
            pick_ptr_s  = select_r + 2'd1;
        end else begin
            beat_s      = 1'b0;
            release_s   = 1'b0;
            pick_mask_s = bus.req;
            pick_ptr_s  = ptr_r;
        end
    end

    rr_pick4 u_pick (
        .mask (pick_mask_s),
        .ptr  (pick_ptr_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    Mux_4_to_1 #(.WIDTH(DATA_W)) u_mux (
        .clk (clk),
        .sel (select_r),
        .in0 (bus.data0),
        .in1 (bus.data1),
        .in2 (bus.data2),
        .in3 (bus.data3),
        .out (mux_data_s)
    );

    // Arbitration FSM with registered grant, select and bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            beat_cnt_r  <= 4'd0;
            grant_r     <= 4'b0000;
            select_r    <= 2'd0;
            bus_data_r  <= '0;
            bus_valid_r <= 1'b0;
        end else begin
            bus_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        state_r    <= BUSY;
                        grant_r    <= onehot2(pick_idx_s);
                        select_r   <= pick_idx_s;
                        beat_cnt_r <= 4'd0;
                    end else begin
                        grant_r <= 4'b0000;
                    end
                end
                BUSY: begin
                    if (beat_s) begin
                        bus_data_r  <= mux_data_s;
                        bus_valid_r <= 1'b1;
                        beat_cnt_r  <= beat_cnt_r + 4'd1;
                    end
                    if (release_s) begin
                        ptr_r      <= select_r + 2'd1;
                        beat_cnt_r <= 4'd0;
                        if (pick_any_s) begin
                            grant_r  <= onehot2(pick_idx_s);
                            select_r <= pick_idx_s;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 4'b0000;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 4'b0000;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Directed bench for rr_bus_arbiter4: vector table plus multi-cycle sequences.
module tb_rr_bus_arbiter4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_bus_arbiter4_if #(.DATA_W(16)) bus_if ();

    rr_bus_arbiter4 #(.DATA_W(16), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive inputs now, then observe outputs 1 time unit after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.req  = 4'b0000;
        bus_if.last = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_data(input logic [15:0] d0);
        bus_if.data0 = d0;
        bus_if.data1 = 16'h2222;
        bus_if.data2 = 16'h3333;
        bus_if.data3 = 16'h4444;
    endtask

    initial begin
        logic [15:0] words [4];
        int          own;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.req  = 4'b0000;
        bus_if.last = 4'b0000;
        set_data(16'hA5A5);

        // Single grant with last on first beat, then last on a non-owner index.
        vecs[0] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 16'h0000};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 16'h3333};
        vecs[2] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0, 16'h3333};
        vecs[3] = '{4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[4] = '{4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[5] = '{4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, 16'hA5A5};
        vecs[6] = '{4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'hA5A5};
        vecs[7] = '{4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'h3333};
        vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h3333};

        do_reset();
        chk("reset_grant", 32'(bus_if.grant), 32'h0);
        chk("reset_select", 32'(bus_if.select), 32'h0);
        chk("reset_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("reset_data", 32'(bus_if.bus_data), 32'h0);

        for (int i = 0; i < 9; i++) begin
            bus_if.req  = vecs[i].req;
            bus_if.last = vecs[i].last;
            step();
            chk($sformatf("vec%0d_grant", i), 32'(bus_if.grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d_select", i), 32'(bus_if.select), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_valid", i), 32'(bus_if.bus_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_data", i), 32'(bus_if.bus_data), 32'(vecs[i].data));
        end

        // Full rotation with all sources requesting and no last.
        set_data(16'h1111);
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        do_reset();
        bus_if.req = 4'b1111;
        for (int t = 1; t <= 21; t++) begin
            step();
            own = ((t - 1) / 4) % 4;
            chk($sformatf("rr_grant_t%0d", t), 32'(bus_if.grant), 32'(4'b0001 << own));
            if (t >= 2) begin
                chk($sformatf("rr_valid_t%0d", t), 32'(bus_if.bus_valid), 32'h1);
                chk($sformatf("rr_data_t%0d", t), 32'(bus_if.bus_data),
                    32'(words[((t - 2) / 4) % 4]));
            end
        end

        // Owner 1 withdraws after two beats while source 3 waits.
        do_reset();
        bus_if.req = 4'b1010;
        step();
        chk("wd_grant1", 32'(bus_if.grant), 32'h2);
        step();
        step();
        chk("wd_valid_beat2", 32'(bus_if.bus_valid), 32'h1);
        bus_if.req = 4'b1000;
        step();
        chk("wd_grant_handoff", 32'(bus_if.grant), 32'h8);
        chk("wd_valid_gap", 32'(bus_if.bus_valid), 32'h0);
        step();
        chk("wd_owner3_valid", 32'(bus_if.bus_valid), 32'h1);
        chk("wd_owner3_data", 32'(bus_if.bus_data), 32'h4444);

        // Lone source 0: four beats, one idle cycle, then regrant.
        set_data(16'hA5A5);
        do_reset();
        bus_if.req = 4'b0001;
        for (int t = 1; t <= 7; t++) begin
            step();
            chk($sformatf("solo_grant_t%0d", t), 32'(bus_if.grant),
                (t == 5) ? 32'h0 : 32'h1);
            chk($sformatf("solo_valid_t%0d", t), 32'(bus_if.bus_valid),
                (t >= 2 && t <= 5) || t == 7 ? 32'h1 : 32'h0);
        end
        chk("solo_data", 32'(bus_if.bus_data), 32'hA5A5);

        // Asynchronous reset in the middle of owner 3's tenure.
        do_reset();
        bus_if.req = 4'b1000;
        step();
        chk("ar_grant_pre", 32'(bus_if.grant), 32'h8);
        step();
        chk("ar_valid_pre", 32'(bus_if.bus_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant_async", 32'(bus_if.grant), 32'h0);
        chk("ar_valid_async", 32'(bus_if.bus_valid), 32'h0);
        chk("ar_select_async", 32'(bus_if.select), 32'h0);
        chk("ar_data_async", 32'(bus_if.bus_data), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_regrant", 32'(bus_if.grant), 32'h8);
        chk("ar_regrant_sel", 32'(bus_if.select), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
